// File: rtl/seqdetect_pkg.sv
// Shared definitions for the serializer feeding the sequence detector.
// Frame length grows by one parity bit when BIT_SERIALIZER_PARITY_EN is defined.
package seqdetect_pkg;

  localparam int DEFAULT_WIDTH = 8;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Frame-position counter: cleared on every (re)load, advanced once per shifted bit,
// flags the final bit of the frame.
module serializer_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_advance,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_advance) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/bit_serializer.sv
// Double-buffered parallel-to-serial converter driving the detector's din.
// Optional even-parity trailer bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import seqdetect_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(WIDTH + 2);

  // Frames are stored so that the bit to transmit next is always the top bit.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] ord;
    rev = {<<{d}};
    ord = (MSB_FIRST != 0) ? d : rev;
`ifdef BIT_SERIALIZER_PARITY_EN
    return {ord, ^d};
`else
    return ord;
`endif
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] w_shift_nxt;
  logic [FRAME_LEN-1:0] r_hold;
  logic [FRAME_LEN-1:0] w_hold_nxt;
  logic                 r_hold_full;
  logic                 w_hold_full_nxt;
  logic [FRAME_LEN-1:0] w_frame_in;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_cnt_load;
  logic                 w_cnt_adv;

  assign w_frame_in = build_frame(data_in);
  assign w_xfer     = data_valid && !r_hold_full;

  serializer_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cnt_load),
    .i_advance (w_cnt_adv),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  // Holding data is qualified by r_hold_full, so it needs no reset.
  always_ff @(posedge clk) begin
    r_hold <= w_hold_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_cnt_load      = 1'b0;
    w_cnt_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_shift_nxt = w_frame_in;
          w_state_nxt = SHIFT;
          w_cnt_load  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) begin
          // End of frame: reload from hold, else from the input, else go idle.
          w_cnt_load = 1'b1;
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_xfer) begin
            w_shift_nxt = w_frame_in;
          end else begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
          end
        end else begin
          w_shift_nxt = {r_shift[FRAME_LEN-2:0], 1'b0};
          w_cnt_adv   = 1'b1;
          if (w_xfer) begin
            w_hold_nxt      = w_frame_in;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data_ready = !r_hold_full;
  assign dout       = r_shift[FRAME_LEN-1];
  assign dout_valid = (r_state == SHIFT);
  assign dout_last  = (r_state == SHIFT) && w_last;
  assign busy       = dout_valid || r_hold_full;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the sequence detector and drives its serial din input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on dout.
- Double-buffered (shift register plus one holding register), so consecutive words stream with no idle cycle between them.

Parameters:
- WIDTH, 8: bits per word; legal range >= 2.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in holds a word.
- data_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; connects to the detector's din.
- dout_valid  output  1  dout carries a frame bit this cycle.
- dout_last  output  1  dout is the final bit of the current frame.
- busy  output  1  shift register or holding register occupied.

Behaviour:
- Reset (asynchronous, immediate):
  - dout=0, dout_valid=0, dout_last=0, busy=0, data_ready=1.
  - Holding register empty, bit counter 0, state IDLE.
  - Any frame in progress and any held word are discarded; no partial completion after reset release.
- Handshake:
  - A transfer occurs at a rising edge where data_valid && data_ready.
  - data_ready = !hold_full, driven from a register only, with no combinational path from data_valid.
  - data_in is sampled only on a transfer.
- States:
  - IDLE: shifter empty. A transfer loads the word directly into the shifter and enters SHIFT. At that same edge, dout = first bit, dout_valid=1, counter=0.
  - SHIFT: each edge advances one bit and increments the counter. The final frame bit (counter = FRAME_LEN-1) drives dout_last=1.
  - At the edge that ends the final bit:
    - Holding full: move the held word into the shifter; the first bit appears at that edge with no gap; hold becomes empty.
    - Holding empty and a transfer occurs at the same edge: the word goes straight into the shifter, also with no gap.
    - Otherwise: return to IDLE; dout=0, dout_valid=0, dout_last=0.
  - A transfer in SHIFT that is not at the final-bit edge writes the holding register; data_ready drops at that edge.
- Latency: first bit appears on dout in the cycle immediately after the accepting edge.
- Frame length:
  - FRAME_LEN = WIDTH.
  - Throughput: one word per FRAME_LEN cycles sustained.
- Counter width: $clog2(WIDTH+2) bits. It is never compared beyond FRAME_LEN-1 and wraps to 0 on reload.
- busy = dout_valid || hold_full.
- With MSB_FIRST=0, bit order is reversed; everything else is identical.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - After the data bits, one even-parity bit (XOR of all data bits, captured at load) is sent.
  - dout_last marks the parity bit; back-to-back rules apply at the end of the parity bit.
- Not defined: FRAME_LEN = WIDTH; no parity logic is synthesized.

Decomposition:
- Shared package/include seqdetect_pkg:
  - Default WIDTH.
  - FRAME_LEN derivation.
  - State encodings IDLE=1'b0, SHIFT=1'b1.
- One natural sub-module: serializer_bit_counter.
  - Holds the frame-position counter.
  - Inputs: load and advance.
  - Output: last flag.
- Shifter and holding register stay in the top module.

Test Plan:
1. Reset 5 cycles, then send 8'hB2 (MSB_FIRST=1) -> next cycle onward, dout = 1,0,1,1,0,0,1,0 with dout_valid=1 for 8 cycles, dout_last on the 8th, then dout_valid=0 and busy=0.
2. Send 8'hB2 then 8'hC0 back-to-back (second offered on the cycle after the first is accepted) -> 16 contiguous valid bits 10110010 11000000; data_ready=0 from the second accept until the reload edge.
3. Hold data_valid high with three words A5, 3C, FF -> third word stalls (data_ready=0) until A5's last bit; all 24 bits are emitted gap-free and in order.
4. Assert rst mid-frame after 3 bits of 8'hB2, with 8'h0F held -> outputs clear immediately; after release, data_ready=1, no residual bits, and a fresh 8'h0F transmits as 00001111.
5. MSB_FIRST=0, send 8'hB2 -> dout = 0,1,0,0,1,1,0,1.
6. BIT_SERIALIZER_PARITY_EN defined:
   - Send 8'hB2 -> 9 bits 10110010 followed by parity 0, dout_last on the 9th bit.
   - Send 8'h07 -> parity bit 1.
